// File: rtl/mem_responder.sv
// Register-file memory responder for the accumulator bus: fixed-latency reads, writes,
// and sticky protocol-error flags. Define MEM_INIT_EN to load mem[i] = i+1 on reset.
module mem_responder #(
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              rden,
  input  logic              wren,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic [2:0]        err,
  input  logic              err_clr,
  output logic [5:0]        wr_count
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [2:0] LatCnt = 3'(READ_LAT);

  logic [DATA_W-1:0] mem_q [Depth];

  logic [DATA_W-1:0] pipe_data_q [READ_LAT];
  logic [DATA_W-1:0] pipe_data_d [READ_LAT];
  logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic [2:0]        err_q, err_d;
  logic [5:0]        wr_count_q, wr_count_d;
  logic [2:0]        burst_q, burst_d;
  logic              prev_wren_q, prev_wren_d;
  logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;

  logic rd_launch;
  logic addr_jump;
  logic conflict;
  logic short_burst;

  assign rd_launch   = rden & ~wren;
  assign conflict    = rden & wren;
  assign addr_jump   = wren & prev_wren_q & (address != prev_addr_q);
  // A burst ends on the first edge with rden low; a saturated count means it was long enough.
  assign short_burst = ~rden & (burst_q != 3'd0) & (burst_q < LatCnt);

  always_comb begin
    pipe_data_d = pipe_data_q;
    pipe_vld_d  = '0;
    pipe_data_d[0] = rd_launch ? mem_q[address] : pipe_data_q[0];
    pipe_vld_d[0]  = rd_launch;
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      pipe_data_d[i] = pipe_data_q[i-1];
      pipe_vld_d[i]  = pipe_vld_q[i-1];
    end

    q_valid_d = pipe_vld_q[READ_LAT-1];
    q_d       = q_valid_d ? pipe_data_q[READ_LAT-1] : q_q;

    if (rden) begin
      burst_d = (burst_q == LatCnt) ? burst_q : burst_q + 3'd1;
    end else begin
      burst_d = 3'd0;
    end

    // Set wins over clear on the same edge.
    err_d = (err_clr ? 3'b000 : err_q) | {short_burst, conflict, addr_jump};

    wr_count_d  = wren ? wr_count_q + 6'd1 : wr_count_q;
    prev_wren_d = wren;
    prev_addr_d = address;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pipe_data_q[i] <= '0;
      end
      pipe_vld_q  <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      err_q       <= 3'b000;
      wr_count_q  <= 6'd0;
      burst_q     <= 3'd0;
      prev_wren_q <= 1'b0;
      prev_addr_q <= '0;
    end else begin
      pipe_data_q <= pipe_data_d;
      pipe_vld_q  <= pipe_vld_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      err_q       <= err_d;
      wr_count_q  <= wr_count_d;
      burst_q     <= burst_d;
      prev_wren_q <= prev_wren_d;
      prev_addr_q <= prev_addr_d;
    end
  end

`ifdef MEM_INIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= DATA_W'(i + 1);
      end
    end else if (wren) begin
      mem_q[address] <= data;
    end
  end
`else
  // No reset on the array so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wren) begin
      mem_q[address] <= data;
    end
  end
`endif

  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign err      = err_q;
  assign wr_count = wr_count_q;

endmodule
